pulse_stretcher: RTL and testbench

Output-side counterpart of the push-button debouncer. The debouncer turns a long, bouncy human press into a single-cycle pulse. This block turns single-cycle game events (mole hit, miss, level-up) into human-visible LED/buzzer pulses of guaranteed minimum length, separated by a guaranteed dark gap. It sits between the game FSM and the board LED/buzzer pins, with one independent channel per event line.

---
 rtl/pulse_stretcher_pkg.sv | 19 +
 rtl/pulse_stretcher_tick_gen.sv | 29 ++
 rtl/pulse_stretcher.sv | 138 +++++++++++++
 tb/tb_pulse_stretcher.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_stretcher_pkg.sv
// Shared types and helpers for the pulse stretcher channels.
package pulse_stretcher_pkg;

  // Per-channel state: dark and ready, lit, or enforced dark gap.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    GAP  = 2'd2
  } stretch_state_t;

  // Width of the per-channel tick counter: must hold max(on_ticks, off_ticks).
  function automatic int unsigned cnt_width(input int unsigned on_ticks,
                                            input int unsigned off_ticks);
    int unsigned m;
    m = (on_ticks > off_ticks) ? on_ticks : off_ticks;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/pulse_stretcher_tick_gen.sv
// Free-running prescaler: one-cycle tick enable every CLK_DIV clocks.
module tick_gen #(
  parameter int unsigned CLK_DIV = 1250000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int unsigned W = $clog2(CLK_DIV);
  localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);

  logic [W-1:0] r_count;

  // Tick is decoded from the registered count, so it is glitch-free enable.
  assign tick = (r_count == LAST);

  // Count 0..CLK_DIV-1 and wrap; reset restarts the phase at 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (tick) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/pulse_stretcher.sv
// Stretches single-cycle event strobes into LED/buzzer pulses of a minimum
// ON length followed by a minimum dark gap, one independent channel per bit.
module pulse_stretcher
  import pulse_stretcher_pkg::*;
#(
  parameter int unsigned N_CH      = 2,
  parameter int unsigned CLK_DIV   = 1250000,
  parameter int unsigned ON_TICKS  = 20,
  parameter int unsigned OFF_TICKS = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] pulse_in,
  input  logic            clr_dropped,
  output logic [N_CH-1:0] pulse_out,
  output logic [N_CH-1:0] busy,
  output logic [N_CH-1:0] dropped
);

  localparam int unsigned CW = cnt_width(ON_TICKS, OFF_TICKS);
  localparam logic [CW-1:0] ON_LAST  = CW'(ON_TICKS - 1);
  localparam logic [CW-1:0] OFF_LAST = CW'(OFF_TICKS - 1);

  logic w_tick;

  // One prescaler shared by every channel.
  tick_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_tick_gen (
    .clk (clk),
    .rst (rst),
    .tick(w_tick)
  );

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    stretch_state_t r_state;
    stretch_state_t w_state_d;
    logic [CW-1:0]  r_cnt;
    logic [CW-1:0]  w_cnt_d;
    logic           r_pending;
    logic           w_pending_d;
    logic           r_dropped;
    logic           w_dropped_d;
    logic           w_drop_set;

    // Next-state: sequencing, one-deep event queue and overflow detection.
    always_comb begin
      w_state_d   = r_state;
      w_cnt_d     = r_cnt;
      w_pending_d = r_pending;
      w_drop_set  = 1'b0;

      unique case (r_state)
        IDLE: begin
          // A tick in this entry cycle is deliberately ignored.
          if (pulse_in[g]) begin
            w_state_d = ON;
            w_cnt_d   = '0;
          end
        end

        ON: begin
          if (w_tick) begin
            if (r_cnt == ON_LAST) begin
              w_state_d = GAP;
              w_cnt_d   = '0;
            end else begin
              w_cnt_d = r_cnt + 1'b1;
            end
          end
          if (pulse_in[g]) begin
            if (r_pending) begin
              w_drop_set = 1'b1;
            end else begin
              w_pending_d = 1'b1;
            end
          end
        end

        GAP: begin
          if (w_tick && (r_cnt == OFF_LAST)) begin
            if (r_pending || pulse_in[g]) begin
              w_state_d = ON;
              w_cnt_d   = '0;
              // The queued event is consumed here; a coincident new event either
              // starts this ON directly (queue empty) or takes the freed slot.
              w_pending_d = r_pending & pulse_in[g];
            end else begin
              w_state_d = IDLE;
              w_cnt_d   = '0;
            end
          end else begin
            if (w_tick) begin
              w_cnt_d = r_cnt + 1'b1;
            end
            if (pulse_in[g]) begin
              if (r_pending) begin
                w_drop_set = 1'b1;
              end else begin
                w_pending_d = 1'b1;
              end
            end
          end
        end

        default: begin
          w_state_d   = IDLE;
          w_cnt_d     = '0;
          w_pending_d = 1'b0;
        end
      endcase

      // Sticky overflow flag; a new drop outranks a simultaneous clear.
      w_dropped_d = (r_dropped & ~clr_dropped) | w_drop_set;
    end

    // Channel state registers with synchronous reset that aborts any pulse.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_state   <= IDLE;
        r_cnt     <= '0;
        r_pending <= 1'b0;
        r_dropped <= 1'b0;
      end else begin
        r_state   <= w_state_d;
        r_cnt     <= w_cnt_d;
        r_pending <= w_pending_d;
        r_dropped <= w_dropped_d;
      end
    end

    // Outputs decode registered state only: no path from pulse_in.
    assign pulse_out[g] = (r_state == ON);
    assign busy[g]      = (r_state != IDLE);
    assign dropped[g]   = r_dropped;
  end

endmodule

// File: tb/tb_pulse_stretcher.sv
// Directed self-checking bench for pulse_stretcher (CLK_DIV=4, ON=3, OFF=2).
module tb_pulse_stretcher;

  localparam int N_CH      = 2;
  localparam int CLK_DIV   = 4;
  localparam int ON_TICKS  = 3;
  localparam int OFF_TICKS = 2;
  localparam int MAXW      = 64;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            clr_dropped = 1'b0;
  logic [N_CH-1:0] pulse_in = '0;
  logic [N_CH-1:0] pulse_out;
  logic [N_CH-1:0] busy;
  logic [N_CH-1:0] dropped;

  int checks = 0;
  int errors = 0;
  int ph = 0;  // prescaler value in the current cycle, tracked by the bench

  logic [N_CH-1:0] inj    [MAXW];
  logic            clr_s  [MAXW];
  logic [N_CH-1:0] rec_po [MAXW];
  logic [N_CH-1:0] rec_bz [MAXW];
  logic [N_CH-1:0] rec_dr [MAXW];

  pulse_stretcher #(
    .N_CH     (N_CH),
    .CLK_DIV  (CLK_DIV),
    .ON_TICKS (ON_TICKS),
    .OFF_TICKS(OFF_TICKS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pulse_in   (pulse_in),
    .clr_dropped(clr_dropped),
    .pulse_out  (pulse_out),
    .busy       (busy),
    .dropped    (dropped)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    ph = rst ? 0 : (ph + 1) % CLK_DIV;
    #1;
  endtask

  task automatic wait_phase(input int p);
    for (int k = 0; k < CLK_DIV; k++) begin
      if (ph != p) cyc();
    end
  endtask

  task automatic clear_sched();
    for (int i = 0; i < MAXW; i++) begin
      inj[i]   = '0;
      clr_s[i] = 1'b0;
    end
  endtask

  // rec[i] holds the outputs in the cycle after inj[i]/clr_s[i] were applied.
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      pulse_in    = inj[i];
      clr_dropped = clr_s[i];
      cyc();
      rec_po[i] = pulse_out;
      rec_bz[i] = busy;
      rec_dr[i] = dropped;
    end
    pulse_in    = '0;
    clr_dropped = 1'b0;
  endtask

  function automatic int n_on(input int ch, input int lo, input int hi);
    int c = 0;
    for (int i = lo; i <= hi; i++) c += int'(rec_po[i][ch]);
    return c;
  endfunction

  function automatic int n_gap(input int ch, input int lo, input int hi);
    int c = 0;
    for (int i = lo; i <= hi; i++) c += int'(rec_bz[i][ch] & ~rec_po[i][ch]);
    return c;
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset from power-up.
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    chk("rst_pulse_out", int'(pulse_out), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_dropped", int'(dropped), 0);

    // Basic stretch at p=0: 11 ON, 8 GAP.
    wait_phase(0);
    clear_sched();
    inj[0] = 2'b01;
    run(30);
    chk("p0_first_cycle_on", int'(rec_po[0][0]), 1);
    chk("p0_on_len", n_on(0, 0, 29), 11);
    chk("p0_gap_len", n_gap(0, 0, 29), 8);
    chk("p0_idle_after", int'(rec_bz[19][0]), 0);
    chk("p0_ch1_quiet", int'(n_on(1, 0, 29) + n_gap(1, 0, 29)), 0);

    // p=3: 12 ON.
    wait_phase(3);
    clear_sched();
    inj[0] = 2'b01;
    run(30);
    chk("p3_on_len", n_on(0, 0, 29), 12);
    chk("p3_gap_len", n_gap(0, 0, 29), 8);

    // p=2: 9 ON.
    wait_phase(2);
    clear_sched();
    inj[0] = 2'b01;
    run(30);
    chk("p2_on_len", n_on(0, 0, 29), 9);
    chk("p2_gap_len", n_gap(0, 0, 29), 8);

    // Queued event: second ON follows the 8-cycle GAP with no IDLE cycle.
    wait_phase(0);
    clear_sched();
    inj[0] = 2'b01;
    inj[5] = 2'b01;
    run(45);
    chk("q_gap_last", int'(rec_po[18][0]), 0);
    chk("q_gap_last_busy", int'(rec_bz[18][0]), 1);
    chk("q_second_on", int'(rec_po[19][0]), 1);
    chk("q_on_total", n_on(0, 0, 44), 23);
    chk("q_gap_total", n_gap(0, 0, 44), 16);
    chk("q_idle_end", int'(rec_bz[39][0]), 0);
    chk("q_no_drop", int'(rec_dr[44][0]), 0);

    // Overflow: three events in one ON -> drop, exactly two ON periods.
    wait_phase(0);
    clear_sched();
    inj[0] = 2'b01;
    inj[3] = 2'b01;
    inj[6] = 2'b01;
    run(45);
    chk("ov_before_drop", int'(rec_dr[5][0]), 0);
    chk("ov_drop_set", int'(rec_dr[6][0]), 1);
    chk("ov_on_total", n_on(0, 0, 44), 23);
    chk("ov_idle_end", int'(rec_bz[39][0]), 0);
    chk("ov_drop_sticky", int'(rec_dr[44][0]), 1);

    // Clear coinciding with a new drop keeps the flag; a lone clear drops it.
    wait_phase(0);
    clear_sched();
    inj[0]   = 2'b01;
    inj[2]   = 2'b01;
    inj[4]   = 2'b01;
    clr_s[4] = 1'b1;
    clr_s[10] = 1'b1;
    run(45);
    chk("clr_set_wins", int'(rec_dr[4][0]), 1);
    chk("clr_held", int'(rec_dr[9][0]), 1);
    chk("clr_alone", int'(rec_dr[10][0]), 0);
    chk("clr_idle_end", int'(rec_bz[44][0]), 0);

    // Coincident event on the GAP-ending tick: ON next cycle, nothing queued.
    wait_phase(0);
    clear_sched();
    inj[0]  = 2'b01;
    inj[19] = 2'b01;
    run(60);
    chk("co_gap_last", int'(rec_po[18][0]), 0);
    chk("co_restart", int'(rec_po[19][0]), 1);
    chk("co_on_total", n_on(0, 0, 59), 23);
    chk("co_no_third", int'(rec_bz[39][0]), 0);
    chk("co_no_drop", int'(rec_dr[59][0]), 0);

    // Simultaneous events on both channels at p=1: 10 ON each.
    wait_phase(1);
    clear_sched();
    inj[0] = 2'b11;
    run(30);
    chk("sim_ch0_on", n_on(0, 0, 29), 10);
    chk("sim_ch1_on", n_on(1, 0, 29), 10);
    chk("sim_ch0_gap", n_gap(0, 0, 29), 8);
    chk("sim_ch1_gap", n_gap(1, 0, 29), 8);

    // Different phases: ch0 at p=3 (12), ch1 at p=2 (9).
    wait_phase(3);
    clear_sched();
    inj[0] = 2'b01;
    inj[3] = 2'b10;
    run(35);
    chk("ind_ch0_on", n_on(0, 0, 34), 12);
    chk("ind_ch0_gap", n_gap(0, 0, 34), 8);
    chk("ind_ch1_before", int'(rec_po[2][1]), 0);
    chk("ind_ch1_start", int'(rec_po[3][1]), 1);
    chk("ind_ch1_on", n_on(1, 0, 34), 9);
    chk("ind_ch1_gap", n_gap(1, 0, 34), 8);

    // Reset mid-pulse with a queued event and a drop outstanding.
    wait_phase(0);
    pulse_in = 2'b01;
    cyc();
    cyc();
    cyc();
    pulse_in = '0;
    chk("mid_pre_on", int'(pulse_out[0]), 1);
    chk("mid_pre_drop", int'(dropped[0]), 1);
    rst = 1'b1;
    cyc();
    chk("mid_rst_pulse_out", int'(pulse_out), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_dropped", int'(dropped), 0);
    cyc();
    rst = 1'b0;

    // Prescaler restarted at 0: immediate event gives the p=0 length, no stale queue.
    clear_sched();
    inj[0] = 2'b01;
    run(30);
    chk("post_rst_on", n_on(0, 0, 29), 11);
    chk("post_rst_gap", n_gap(0, 0, 29), 8);
    chk("post_rst_idle", int'(rec_bz[29][0]), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
